traffic_light_ctrl: RTL and testbench

Two-road intersection controller: the parametrised successor to the single-road red/yellow/green sequencer. Drives north-south (NS) and east-west (EW) lamp sets through green, yellow and all-red clearance phases with configurable durations. Exposes a shared countdown and a pedestrian request that shortens the active green. Adds a flashing-yellow maintenance mode. Sits at the top of the traffic demo, fed by a debounced button and a mode switch.

---
 rtl/traffic_pkg.sv | 53 +++++
 rtl/traffic_light_ctrl_phase_timer.sv | 37 +++
 rtl/traffic_light_ctrl.sv | 136 +++++++++++++
 tb/tb_traffic_light_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp patterns and phase-sequencing helpers for the
// two-road intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        FLASH     = 3'd6
    } phase_e;

    // Lamp vectors are {red, yellow, green}
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    function automatic phase_e next_phase(phase_e p);
        phase_e n;
        case (p)
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = ALLRED_A;
            ALLRED_A:  n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            EW_YELLOW: n = ALLRED_B;
            ALLRED_B:  n = NS_GREEN;
            default:   n = ALLRED_B;
        endcase
        return n;
    endfunction

    function automatic logic is_green(phase_e p);
        return (p == NS_GREEN) || (p == EW_GREEN);
    endfunction

    // Lamp pattern for one road; ew selects the east-west road.
    function automatic logic [2:0] road_lamp(phase_e p, logic blink, logic ew);
        logic [2:0] l;
        l = LAMP_RED;
        if (p == FLASH) begin
            l = blink ? LAMP_YELLOW : LAMP_OFF;
        end else if (p == (ew ? EW_GREEN : NS_GREEN)) begin
            l = LAMP_GREEN;
        end else if (p == (ew ? EW_YELLOW : NS_YELLOW)) begin
            l = LAMP_YELLOW;
        end
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Loadable down-counter holding the cycles left in the current phase.
module phase_timer #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RST_VAL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic [CNT_W-1:0] remain,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!hold) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign remain = cnt_q;
    assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: green/yellow/all-red ring with pedestrian
// shortening and a flashing-yellow maintenance mode.
module traffic_light_ctrl #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned GREEN_T  = 60,
    parameter int unsigned YELLOW_T = 5,
    parameter int unsigned ALLRED_T = 2,
    parameter int unsigned SHORT_T  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ped_req,
    input  logic             flash,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [CNT_W-1:0] remain,
    output logic [2:0]       phase,
    output logic             ped_pend
);
    import traffic_pkg::*;

    localparam int unsigned MAX_T = (CNT_W >= 1 && CNT_W <= 31) ? (1 << CNT_W) - 1 : 0;

    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_width
        $error("traffic_light_ctrl: CNT_W out of range");
    end
    if (GREEN_T < 1 || GREEN_T > MAX_T || YELLOW_T < 1 || YELLOW_T > MAX_T ||
        ALLRED_T < 1 || ALLRED_T > MAX_T || SHORT_T < 1 || SHORT_T >= GREEN_T) begin : g_bad_dur
        $error("traffic_light_ctrl: durations must be 1..2^CNT_W-1 with SHORT_T < GREEN_T");
    end

    localparam logic [CNT_W-1:0] GREEN_L  = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] ALLRED_L = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] SHORT_L  = CNT_W'(SHORT_T);

    phase_e           phase_q, phase_d;
    logic             ped_pend_q, ped_pend_d;
    logic             blink_q, blink_d;
    logic [2:0]       ns_q, ew_q;
    logic             load, hold, expire;
    logic [CNT_W-1:0] load_val, remain_w;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_T)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .hold     (hold),
        .remain   (remain_w),
        .expire   (expire)
    );

    function automatic logic [CNT_W-1:0] duration(phase_e p);
        logic [CNT_W-1:0] d;
        case (p)
            NS_GREEN, EW_GREEN:   d = GREEN_L;
            NS_YELLOW, EW_YELLOW: d = YELLOW_L;
            default:              d = ALLRED_L;
        endcase
        return d;
    endfunction

    // Priority: flash, leaving flash, phase expiry, pedestrian request.
    always_comb begin
        phase_d    = phase_q;
        ped_pend_d = ped_pend_q;
        blink_d    = 1'b0;
        load       = 1'b0;
        hold       = 1'b0;
        load_val   = remain_w;
        if (flash) begin
            phase_d    = FLASH;
            ped_pend_d = 1'b0;
            if (phase_q == FLASH) begin
                hold    = 1'b1;
                blink_d = ~blink_q;
            end else begin
                load     = 1'b1;
                load_val = '0;
                blink_d  = 1'b1;
            end
        end else if (phase_q == FLASH) begin
            phase_d  = ALLRED_B;
            load     = 1'b1;
            load_val = ALLRED_L;
        end else if (expire) begin
            phase_d  = next_phase(phase_q);
            load     = 1'b1;
            load_val = duration(phase_d);
            if (is_green(phase_d)) begin
                if (ped_pend_q || ped_req) begin
                    load_val = SHORT_L;
                end
                ped_pend_d = 1'b0;
            end else if (ped_req && !is_green(phase_q)) begin
                ped_pend_d = 1'b1;
            end
        end else if (ped_req) begin
            if (is_green(phase_q)) begin
                if (remain_w > SHORT_L) begin
                    load     = 1'b1;
                    load_val = SHORT_L;
                end
            end else begin
                ped_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= ALLRED_B;
            ped_pend_q <= 1'b0;
            blink_q    <= 1'b0;
            ns_q       <= LAMP_RED;
            ew_q       <= LAMP_RED;
        end else begin
            phase_q    <= phase_d;
            ped_pend_q <= ped_pend_d;
            blink_q    <= blink_d;
            ns_q       <= road_lamp(phase_d, blink_d, 1'b0);
            ew_q       <= road_lamp(phase_d, blink_d, 1'b1);
        end
    end

    assign ns_light = ns_q;
    assign ew_light = ew_q;
    assign remain   = remain_w;
    assign phase    = phase_q;
    assign ped_pend = ped_pend_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: default and small-parameter instances run in
// lockstep against a phase/duration reference model.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst, ped_req, flash;
    logic [2:0] ns_d, ew_d, ph_d, ns_s, ew_s, ph_s;
    logic [7:0] rem_d;
    logic [3:0] rem_s;
    logic       pend_d, pend_s;
    int         n_vec = 0;
    int         n_err = 0;

    typedef struct {
        int ph;
        int rem;
        bit pend;
        bit blink;
    } model_t;

    // Configuration 0 = defaults, 1 = small instance
    int G[2] = '{60, 12};
    int Y[2] = '{5, 2};
    int A[2] = '{2, 1};
    int S[2] = '{10, 3};
    model_t md, ms;

    always #5 clk = ~clk;

    traffic_light_ctrl dut (
        .clk(clk), .rst(rst), .ped_req(ped_req), .flash(flash),
        .ns_light(ns_d), .ew_light(ew_d), .remain(rem_d), .phase(ph_d), .ped_pend(pend_d)
    );

    traffic_light_ctrl #(
        .CNT_W(4), .GREEN_T(12), .YELLOW_T(2), .ALLRED_T(1), .SHORT_T(3)
    ) dut_s (
        .clk(clk), .rst(rst), .ped_req(ped_req), .flash(flash),
        .ns_light(ns_s), .ew_light(ew_s), .remain(rem_s), .phase(ph_s), .ped_pend(pend_s)
    );

    // Phase index 0..5 is the ring order, 6 is maintenance flash.
    function automatic model_t model_step(model_t m, int c, bit p, bit f);
        model_t n;
        bit     wg;
        n  = m;
        wg = (m.ph == 0 || m.ph == 3);
        if (f) begin
            n.ph = 6; n.rem = 0; n.pend = 0;
            n.blink = (m.ph == 6) ? !m.blink : 1'b1;
        end else if (m.ph == 6) begin
            n.ph = 5; n.rem = A[c]; n.blink = 0;
        end else if (m.rem == 1) begin
            n.ph = (m.ph + 1) % 6;
            if (n.ph == 0 || n.ph == 3) begin
                n.rem  = (m.pend || p) ? S[c] : G[c];
                n.pend = 0;
            end else begin
                n.rem = (n.ph == 1 || n.ph == 4) ? Y[c] : A[c];
                if (p && !wg) n.pend = 1;
            end
        end else begin
            n.rem = m.rem - 1;
            if (p && wg && m.rem > S[c]) n.rem = S[c];
            if (p && !wg) n.pend = 1;
        end
        return n;
    endfunction

    function automatic model_t model_reset(int c);
        model_t m;
        m.ph = 5; m.rem = A[c]; m.pend = 0; m.blink = 0;
        return m;
    endfunction

    function automatic logic [2:0] m_lamp(model_t m, bit ew);
        if (m.ph == 6) return m.blink ? 3'b010 : 3'b000;
        if (m.ph == (ew ? 3 : 0)) return 3'b001;
        if (m.ph == (ew ? 4 : 1)) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [17:0] obs_d();
        return {ph_d, rem_d, ns_d, ew_d, pend_d};
    endfunction
    function automatic logic [13:0] obs_s();
        return {ph_s, rem_s, ns_s, ew_s, pend_s};
    endfunction
    function automatic logic [17:0] exp_d();
        return {3'(md.ph), 8'(md.rem), m_lamp(md, 1'b0), m_lamp(md, 1'b1), md.pend};
    endfunction
    function automatic logic [13:0] exp_s();
        return {3'(ms.ph), 4'(ms.rem), m_lamp(ms, 1'b0), m_lamp(ms, 1'b1), ms.pend};
    endfunction

    task automatic tick(input bit p, input bit f);
        ped_req = p;
        flash   = f;
        md = model_step(md, 0, p, f);
        ms = model_step(ms, 1, p, f);
        @(posedge clk);
        #1;
    endtask

    // Lamp sanity, conflict and countdown bound on every cycle
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_vec++;
            if (!$onehot0(ns_d) || !$onehot0(ew_d) || !$onehot0(ns_s) || !$onehot0(ew_s) ||
                ((|ns_d[1:0]) && (|ew_d[1:0]) && ph_d != 3'd6) ||
                ((|ns_s[1:0]) && (|ew_s[1:0]) && ph_s != 3'd6) ||
                rem_d > 8'd60 || rem_s > 4'd12) begin
                n_err++;
                $display("FAIL invariant t=%0t ns/ew=%b/%b small ns/ew=%b/%b remain=%0d/%0d",
                         $time, ns_d, ew_d, ns_s, ew_s, rem_d, rem_s);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; ped_req = 1'b0; flash = 1'b0;
        md = model_reset(0); ms = model_reset(1);
        @(posedge clk); #1;
        n_vec++;
        if (obs_d() !== {3'd5, 8'd2, 3'b100, 3'b100, 1'b0} ||
            obs_s() !== {3'd5, 4'd1, 3'b100, 3'b100, 1'b0}) begin
            n_err++;
            $display("FAIL reset got %h/%h want %h/%h", obs_d(), obs_s(),
                     {3'd5, 8'd2, 3'b100, 3'b100, 1'b0}, {3'd5, 4'd1, 3'b100, 3'b100, 1'b0});
        end
        rst = 1'b0;
    endtask

    task automatic test_ring();
        for (int i = 1; i <= 270; i++) begin
            tick(1'b0, 1'b0);
            n_vec++;
            if ({obs_d(), obs_s()} !== {exp_d(), exp_s()}) begin
                n_err++;
                $display("FAIL ring@%0d dut=%h/%h model=%h/%h", i, obs_d(), obs_s(), exp_d(), exp_s());
            end
            if (i == 2 || i == 136 || i == 270 || i == 62 || i == 67 || i == 69) begin
                n_vec++;
                if ({ph_d, rem_d} !== (i == 62 ? {3'd1, 8'd5} : i == 67 ? {3'd2, 8'd2} :
                                       i == 69 ? {3'd3, 8'd60} : {3'd0, 8'd60})) begin
                    n_err++;
                    $display("FAIL ring_phase@%0d got phase=%0d remain=%0d", i, ph_d, rem_d);
                end
            end
            if (i == 1 || i == 31 || i == 61 || i == 91) begin
                n_vec++;
                if ({ph_s, rem_s} !== {3'd0, 4'd12}) begin
                    n_err++;
                    $display("FAIL small_ring@%0d got phase=%0d remain=%0d want 0/12", i, ph_s, rem_s);
                end
            end
        end
    endtask

    task automatic test_ped_green();
        int n;
        n = 0;
        while (!(ph_d == 3'd0 && rem_d == 8'd45) && n < 300) begin
            tick(1'b0, 1'b0);
            n++;
        end
        tick(1'b1, 1'b0);
        n_vec++;
        if ({ph_d, rem_d} !== {3'd0, 8'd10}) begin
            n_err++;
            $display("FAIL ped_shorten got phase=%0d remain=%0d want 0/10", ph_d, rem_d);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            n_vec++;
            if ({obs_d(), obs_s()} !== {exp_d(), exp_s()}) begin
                n_err++;
                $display("FAIL ped_green dut=%h/%h model=%h/%h", obs_d(), obs_s(), exp_d(), exp_s());
            end
        end
        n_vec++;
        if ({ph_d, rem_d} !== {3'd1, 8'd5}) begin
            n_err++;
            $display("FAIL ped_yellow got phase=%0d remain=%0d want 1/5", ph_d, rem_d);
        end
        n = 0;
        while (!(ph_d == 3'd0 && rem_d == 8'd7) && n < 300) begin
            tick(1'b0, 1'b0);
            n++;
        end
        tick(1'b1, 1'b0);
        n_vec++;
        if ({ph_d, rem_d, pend_d} !== {3'd0, 8'd6, 1'b0} || n >= 300) begin
            n_err++;
            $display("FAIL ped_late got phase=%0d remain=%0d pend=%0b want 0/6/0", ph_d, rem_d, pend_d);
        end
    endtask

    task automatic test_ped_pending();
        int n;
        n = 0;
        while (ph_d != 3'd1 && n < 300) begin
            tick(1'b0, 1'b0);
            n++;
        end
        tick(1'b1, 1'b0);
        n_vec++;
        if ({ph_d, pend_d} !== {3'd1, 1'b1}) begin
            n_err++;
            $display("FAIL ped_pend_set got phase=%0d pend=%0b want 1/1", ph_d, pend_d);
        end
        n = 0;
        while (ph_d != 3'd3 && n < 300) begin
            tick(1'b0, 1'b0);
            n_vec++;
            if ({obs_d(), obs_s()} !== {exp_d(), exp_s()}) begin
                n_err++;
                $display("FAIL ped_pend dut=%h/%h model=%h/%h", obs_d(), obs_s(), exp_d(), exp_s());
            end
            n++;
        end
        n_vec++;
        if ({ph_d, rem_d, pend_d} !== {3'd3, 8'd10, 1'b0}) begin
            n_err++;
            $display("FAIL ped_pend_use got phase=%0d remain=%0d pend=%0b want 3/10/0",
                     ph_d, rem_d, pend_d);
        end
    endtask

    task automatic test_flash();
        int n;
        n = 0;
        while (!(ph_d == 3'd3 && rem_d == 8'd30) && n < 300) begin
            tick(1'b0, 1'b0);
            n++;
        end
        for (int k = 0; k < 6; k++) begin
            tick(k == 2, 1'b1);
            n_vec++;
            if ({ph_d, rem_d, ns_d, ew_d, pend_d} !==
                {3'd6, 8'd0, (k % 2 == 0) ? 3'b010 : 3'b000, (k % 2 == 0) ? 3'b010 : 3'b000, 1'b0}) begin
                n_err++;
                $display("FAIL flash@%0d got phase=%0d remain=%0d ns=%b ew=%b pend=%0b",
                         k, ph_d, rem_d, ns_d, ew_d, pend_d);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0);
            n_vec++;
            if ({ph_d, rem_d, ns_d} !== (k == 0 ? {3'd5, 8'd2, 3'b100} :
                                        k == 1 ? {3'd5, 8'd1, 3'b100} : {3'd0, 8'd60, 3'b001})) begin
                n_err++;
                $display("FAIL flash_exit@%0d got phase=%0d remain=%0d ns=%b", k, ph_d, rem_d, ns_d);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (ph_d != 3'd1 && n < 300) begin
            tick(1'b0, 1'b0);
            n++;
        end
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if (obs_d() !== {3'd5, 8'd2, 3'b100, 3'b100, 1'b0} ||
            obs_s() !== {3'd5, 4'd1, 3'b100, 3'b100, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset got %h/%h", obs_d(), obs_s());
        end
        md = model_reset(0); ms = model_reset(1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            tick(1'b0, 1'b0);
            n_vec++;
            if ({obs_d(), obs_s()} !== {exp_d(), exp_s()} ||
                (i == 2 && {ph_d, rem_d} !== {3'd0, 8'd60})) begin
                n_err++;
                $display("FAIL restart@%0d dut=%h/%h model=%h/%h", i, obs_d(), obs_s(), exp_d(), exp_s());
            end
        end
    endtask

    task automatic test_random();
        int fl_left;
        fl_left = 0;
        for (int i = 0; i < 4000; i++) begin
            bit p, f;
            if (fl_left == 0 && $urandom_range(0, 299) == 0) fl_left = $urandom_range(1, 12);
            f = (fl_left != 0);
            if (fl_left != 0) fl_left--;
            p = ($urandom_range(0, 15) == 0);
            tick(p, f);
            n_vec++;
            if ({obs_d(), obs_s()} !== {exp_d(), exp_s()}) begin
                n_err++;
                $display("FAIL random@%0d dut=%h/%h model=%h/%h", i, obs_d(), obs_s(), exp_d(), exp_s());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ring();
        test_ped_green();
        test_ped_pending();
        test_flash();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
